up_ramcfg_nr_arb: RTL
=====================

UP_RAMCFG_NR_ARB -- requirements
Module: up_ramcfg_nr_arb

Interface
REQ-001 SHALL have parameter G_ADDR, default 10: address width.
REQ-002 SHALL have parameter G_WIDTH, default 32: data width.
REQ-003 SHALL have parameter G_NENG, default 2, legal 1..4: number of engine read ports.
REQ-004 SHALL have parameter G_RDLAT, default 3, legal 1..4: external memory read latency (omemre to imemdo).
REQ-005 SHALL have parameter G_STARVE, default 8, legal 2..255: maximum blocked cycles for a pending CPU read.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 eng_re  in  G_NENG  per-port engine read request.
REQ-009 eng_ra  in  G_NENG*G_ADDR  per-port read address; port i in bits [i*G_ADDR +: G_ADDR].
REQ-010 eng_gnt  out  G_NENG  one-hot grant, same cycle as request (combinational).
REQ-011 eng_rvld  out  G_NENG  one-hot; data valid for the granted port, G_RDLAT cycles after grant.
REQ-012 eng_rdd  out  G_WIDTH  shared engine read data, qualified by eng_rvld.
REQ-013 upen/upws/uprs  in  1 each  CPU enable, write strobe, read strobe.
REQ-014 upa  in  G_ADDR; updi  in  G_WIDTH: CPU address, write data.
REQ-015 updo  out  G_WIDTH; uprdy  out  1: CPU read data, one-cycle access-done pulse.
REQ-016 omemwe out 1, omemwa out G_ADDR, omemdi out G_WIDTH: memory write port.
REQ-017 omemre out 1, omemra out G_ADDR, imemdo in G_WIDTH: memory read port.

Function
REQ-018 CPU write (upen&upws) SHALL be accepted immediately: omemwe=1, omemwa=upa, omemdi=updi, same cycle.
REQ-019 Engine arbitration SHALL be fixed priority, lowest index wins; exactly one eng_gnt bit when any eng_re is set and no CPU slot is forced.
REQ-020 A CPU read SHALL set a pending latch; latch clears on read service or upen=0 (abort, no uprdy).
REQ-021 Pending CPU read SHALL be served same cycle if no engine is granted, or if the granted engine address equals upa (one shared memory read serves both).
REQ-022 omemre SHALL be (any grant | CPU read served); omemra = granted engine address, else upa.
REQ-023 A 2-bit-plus-tag pipeline of depth G_RDLAT SHALL carry the granted port index, engine-valid, CPU-valid, and bypass flags; eng_rvld/uprdy assert exactly G_RDLAT cycles after issue.
REQ-024 CPU write uprdy SHALL also assert G_RDLAT cycles after acceptance.
REQ-025 Same-cycle CPU write and served read at same address SHALL return updi (captured in pipeline) instead of imemdo; omemre suppressed that cycle.
REQ-026 updo SHALL equal eng_rdd source (imemdo or bypassed data) during uprdy for reads; don't-care otherwise.
REQ-027 Starvation counter (8 bit) SHALL increment each cycle the CPU read is pending and not served; clear on service or abort.
REQ-028 When counter reaches G_STARVE, next cycle SHALL force the CPU slot: all eng_gnt=0, CPU read issued; engines retry.
REQ-029 Back-to-back issues every cycle SHALL be supported with no bubbles.

Reset
REQ-030 While rst=1: pending latch, counter, and pipeline cleared; eng_gnt, eng_rvld, uprdy, omemwe, omemre = 0; eng_rdd/updo = 0.
REQ-031 Reset mid-operation SHALL drop all in-flight reads; no eng_rvld/uprdy for them after release.

Configuration
REQ-032 Macro UP_RAMCFG_STARVE_GUARD_EN SHALL compile in REQ-027/028; when undefined, no counter exists and the CPU read waits indefinitely behind engines (engine priority absolute).

Verification
REQ-033 G_RDLAT=3, eng_re=01, eng_ra0=0x10, no CPU -> eng_gnt=01, omemra=0x10, eng_rvld=01 at +3, eng_rdd=imemdo.
REQ-034 eng_re=11, ra0=0x04, ra1=0x08 -> gnt=01; next cycle eng_re=10 -> gnt=10; rvld 01 then 10 on consecutive cycles.
REQ-035 CPU read upa=0x20 with eng_re0 ra=0x20 -> single omemre, eng_rvld=01 and uprdy both at +3, same data.
REQ-036 Engine 0 requests continuously at 0x01, CPU read 0x02, G_STARVE=8, macro defined -> CPU forced after 8 blocked cycles, eng_gnt=00 that cycle, uprdy 3 cycles later; macro undefined -> no uprdy.
REQ-037 CPU write 0x30 data 0xDEADBEEF same cycle as engine read 0x30 -> omemre=0, eng_rdd=0xDEADBEEF at +3.
REQ-038 rst pulsed one cycle after engine grant -> no eng_rvld at +3; outputs zero during reset.

Source files
------------

// File: rtl/up_ramcfg_nr_arb_if.sv
// Signal bundle for up_ramcfg_nr_arb: engine read ports, CPU access port and external RAM ports.
// The slave side is the arbiter; the master side is the surrounding engines, CPU and memory.
interface up_ramcfg_nr_arb_if #(
  parameter int G_ADDR  = 10,
  parameter int G_WIDTH = 32,
  parameter int G_NENG  = 2
);
  logic [G_NENG-1:0]        eng_re;
  logic [G_NENG*G_ADDR-1:0] eng_ra;
  logic [G_NENG-1:0]        eng_gnt;
  logic [G_NENG-1:0]        eng_rvld;
  logic [G_WIDTH-1:0]       eng_rdd;
  logic                     upen;
  logic                     upws;
  logic                     uprs;
  logic [G_ADDR-1:0]        upa;
  logic [G_WIDTH-1:0]       updi;
  logic [G_WIDTH-1:0]       updo;
  logic                     uprdy;
  logic                     omemwe;
  logic [G_ADDR-1:0]        omemwa;
  logic [G_WIDTH-1:0]       omemdi;
  logic                     omemre;
  logic [G_ADDR-1:0]        omemra;
  logic [G_WIDTH-1:0]       imemdo;

  modport master (
    output eng_re, eng_ra, upen, upws, uprs, upa, updi, imemdo,
    input  eng_gnt, eng_rvld, eng_rdd, updo, uprdy,
           omemwe, omemwa, omemdi, omemre, omemra
  );

  modport slave (
    input  eng_re, eng_ra, upen, upws, uprs, upa, updi, imemdo,
    output eng_gnt, eng_rvld, eng_rdd, updo, uprdy,
           omemwe, omemwa, omemdi, omemre, omemra
  );
endinterface

// File: rtl/up_ramcfg_nr_arb.sv
// Shared RAM read arbiter: fixed-priority engine ports plus a CPU port with write bypass.
// Optional CPU starvation guard compiled in by `define UP_RAMCFG_STARVE_GUARD_EN.
module up_ramcfg_nr_arb #(
  parameter int G_ADDR   = 10,
  parameter int G_WIDTH  = 32,
  parameter int G_NENG   = 2,
  parameter int G_RDLAT  = 3,
  parameter int G_STARVE = 8
) (
  input logic               clk,
  input logic               rst,
  up_ramcfg_nr_arb_if.slave bus
);
  // state  | meaning
  // S_IDLE | no CPU read outstanding
  // S_PEND | CPU read strobed, still waiting for a memory read slot
  typedef enum logic {S_IDLE, S_PEND} state_t;

  localparam int L = G_RDLAT - 1;

  state_t             state_q, state_d;
  logic               cpu_wr, cpu_rd, cpu_srv, force_cpu;
  logic               any_re, eng_iss, issue, byp;
  logic [1:0]         gnt_idx;
  logic [G_NENG-1:0]  gnt_oh, rvld;
  logic [G_ADDR-1:0]  gnt_addr, rd_addr;

  logic [G_RDLAT-1:0] p_eng, p_cpu, p_byp;
  logic [1:0]         p_idx [G_RDLAT];
  logic [G_WIDTH-1:0] p_dat [G_RDLAT];
  logic               out_eng, out_cpu;
  logic [G_WIDTH-1:0] rd_src;

  assign cpu_wr = bus.upen & bus.upws;
  assign cpu_rd = bus.upen & (bus.uprs | (state_q == S_PEND));

`ifdef UP_RAMCFG_STARVE_GUARD_EN
  logic [7:0] starve_q;

  assign force_cpu = cpu_rd && (starve_q >= 8'(G_STARVE));

  always_ff @(posedge clk) begin
    if (rst)                    starve_q <= '0;
    else if (cpu_rd && !cpu_srv) starve_q <= (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
    else                        starve_q <= '0;
  end
`else
  assign force_cpu = 1'b0;
`endif

  // descending scan so the lowest requesting index is the last one written
  always_comb begin
    gnt_oh   = '0;
    gnt_idx  = '0;
    gnt_addr = '0;
    any_re   = 1'b0;
    for (int i = G_NENG - 1; i >= 0; i--) begin
      if (bus.eng_re[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_idx   = 2'(i);
        gnt_addr  = bus.eng_ra[i*G_ADDR +: G_ADDR];
        any_re    = 1'b1;
      end
    end
  end

  assign eng_iss = any_re && !force_cpu;
  assign cpu_srv = cpu_rd && (force_cpu || !any_re || (gnt_addr == bus.upa));
  assign issue   = eng_iss || cpu_srv;
  assign rd_addr = eng_iss ? gnt_addr : bus.upa;
  assign byp     = issue && cpu_wr && (rd_addr == bus.upa);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cpu_rd && !cpu_srv) state_d = S_PEND;
      S_PEND:  if (!cpu_rd || cpu_srv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // stage 0 is loaded in the issue cycle; stage L lines up with imemdo
  always_ff @(posedge clk) begin
    if (rst) begin
      p_eng <= '0;
      p_cpu <= '0;
      p_byp <= '0;
      for (int i = 0; i < G_RDLAT; i++) begin
        p_idx[i] <= '0;
        p_dat[i] <= '0;
      end
    end else begin
      p_eng[0] <= eng_iss;
      p_cpu[0] <= cpu_srv || cpu_wr;
      p_byp[0] <= byp;
      p_idx[0] <= gnt_idx;
      p_dat[0] <= byp ? bus.updi : '0;
      for (int i = 1; i < G_RDLAT; i++) begin
        p_eng[i] <= p_eng[i-1];
        p_cpu[i] <= p_cpu[i-1];
        p_byp[i] <= p_byp[i-1];
        p_idx[i] <= p_idx[i-1];
        p_dat[i] <= p_dat[i-1];
      end
    end
  end

  assign out_eng = p_eng[L] & ~rst;
  assign out_cpu = p_cpu[L] & ~rst;
  assign rd_src  = p_byp[L] ? p_dat[L] : bus.imemdo;

  always_comb begin
    rvld = '0;
    for (int i = 0; i < G_NENG; i++) begin
      if (out_eng && (p_idx[L] == 2'(i))) rvld[i] = 1'b1;
    end
  end

  assign bus.eng_gnt  = (rst || force_cpu) ? '0 : gnt_oh;
  assign bus.eng_rvld = rvld;
  assign bus.eng_rdd  = (out_eng || out_cpu) ? rd_src : '0;
  assign bus.updo     = out_cpu ? rd_src : '0;
  assign bus.uprdy    = out_cpu;
  assign bus.omemwe   = cpu_wr & ~rst;
  assign bus.omemwa   = bus.upa;
  assign bus.omemdi   = bus.updi;
  assign bus.omemre   = issue & ~byp & ~rst;
  assign bus.omemra   = rd_addr;
endmodule
